// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with integrated storage.
//
// Binary read/write pointers carry one extra wrap bit, so the low ADDRSIZE
// bits address the storage and the MSB tells full apart from empty. Every
// status output is a register loaded from next-state values. As a result,
// each flag is already correct after the edge that changes occupancy.
//
// Parameters:
//   DATASIZE   - word width in bits
//   ADDRSIZE   - log2 of depth (DEPTH = 2**ADDRSIZE)
//   AFULL_LVL  - walmost_full when occupancy >= AFULL_LVL (1..DEPTH)
//   AEMPTY_LVL - ralmost_empty when occupancy <= AEMPTY_LVL (0..DEPTH-1)
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   synchronous reset, active-high (highest priority)
//   clr           in   synchronous flush, active-high; winc/rinc ignored
//   winc, wdata   in   write request and data
//   rinc          in   read request
//   rdata         out  head-of-queue word (combinational, valid while !rempty)
//   wfull         out  FIFO full
//   rempty        out  FIFO empty
//   walmost_full  out  occupancy >= AFULL_LVL
//   ralmost_empty out  occupancy <= AEMPTY_LVL
//   count         out  occupancy 0..DEPTH
//   overflow      out  sticky: write attempted while full
//   underflow     out  sticky: read attempted while empty
module sync_fifo #(
    parameter int DATASIZE   = 8,
    parameter int ADDRSIZE   = 4,
    parameter int AFULL_LVL  = (1 << ADDRSIZE) - 2,
    parameter int AEMPTY_LVL = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                winc,
    input  logic [DATASIZE-1:0] wdata,
    input  logic                rinc,
    output logic [DATASIZE-1:0] rdata,
    output logic                wfull,
    output logic                rempty,
    output logic                walmost_full,
    output logic                ralmost_empty,
    output logic [ADDRSIZE:0]   count,
    output logic                overflow,
    output logic                underflow
);

    localparam int DEPTH = 1 << ADDRSIZE;
    localparam logic [ADDRSIZE:0] AFULL_C  = (ADDRSIZE+1)'(AFULL_LVL);
    localparam logic [ADDRSIZE:0] AEMPTY_C = (ADDRSIZE+1)'(AEMPTY_LVL);

    logic [DATASIZE-1:0] mem [DEPTH];

    logic [ADDRSIZE:0] wptr, rptr;
    logic [ADDRSIZE:0] wptr_next, rptr_next, count_next;
    logic              wa, ra;

    // Acceptance depends only on the registered flags. Because of this, a
    // write and a read issued together at a boundary resolve deterministically.
    assign wa = winc & ~wfull;
    assign ra = rinc & ~rempty;

    assign wptr_next  = wptr + (ADDRSIZE+1)'(wa);
    assign rptr_next  = rptr + (ADDRSIZE+1)'(ra);
    assign count_next = count + (ADDRSIZE+1)'(wa) - (ADDRSIZE+1)'(ra);

    assign rdata = mem[rptr[ADDRSIZE-1:0]];

    // Storage is never reset. A flush discards the pending write, so stale
    // contents can never become visible again.
    always_ff @(posedge clk) begin
        if (wa && !rst && !clr) begin
            mem[wptr[ADDRSIZE-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wptr          <= '0;
            rptr          <= '0;
            count         <= '0;
            wfull         <= 1'b0;
            rempty        <= 1'b1;
            walmost_full  <= 1'b0;
            ralmost_empty <= 1'b1;
            overflow      <= 1'b0;
            underflow     <= 1'b0;
        end else begin
            wptr          <= wptr_next;
            rptr          <= rptr_next;
            count         <= count_next;
            // Full: same address, opposite wrap bits.
            wfull         <= (wptr_next[ADDRSIZE] != rptr_next[ADDRSIZE]) &&
                             (wptr_next[ADDRSIZE-1:0] == rptr_next[ADDRSIZE-1:0]);
            rempty        <= (wptr_next == rptr_next);
            walmost_full  <= (count_next >= AFULL_C);
            ralmost_empty <= (count_next <= AEMPTY_C);
            overflow      <= overflow  | (winc & wfull);
            underflow     <= underflow | (rinc & rempty);
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       winc = 1'b0, rinc = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic       wfull, rempty, walmost_full, ralmost_empty, overflow, underflow;
    logic [4:0] count;

    logic       winc2 = 1'b0, rinc2 = 1'b0;
    logic [7:0] wdata2 = 8'h00;
    logic [7:0] rdata2;
    logic       wfull2, rempty2, walmost_full2, ralmost_empty2, overflow2, underflow2;
    logic [4:0] count2;

    int checks = 0;
    int errors = 0;

    // Scoreboard for the default-parameter instance.
    logic [7:0] q[$];
    logic [7:0] last_rd, last_exp;
    bit         last_pop;

    always #5 clk = ~clk;

    sync_fifo #(.DATASIZE(8), .ADDRSIZE(4)) dut (
        .clk(clk), .rst(rst), .clr(clr), .winc(winc), .wdata(wdata), .rinc(rinc),
        .rdata(rdata), .wfull(wfull), .rempty(rempty), .walmost_full(walmost_full),
        .ralmost_empty(ralmost_empty), .count(count), .overflow(overflow), .underflow(underflow)
    );

    sync_fifo #(.DATASIZE(8), .ADDRSIZE(4), .AFULL_LVL(16), .AEMPTY_LVL(0)) dut2 (
        .clk(clk), .rst(rst), .clr(clr), .winc(winc2), .wdata(wdata2), .rinc(rinc2),
        .rdata(rdata2), .wfull(wfull2), .rempty(rempty2), .walmost_full(walmost_full2),
        .ralmost_empty(ralmost_empty2), .count(count2), .overflow(overflow2), .underflow(underflow2)
    );

    // Drive one cycle of traffic and keep the scoreboard in step.
    // rdata is captured before the edge, which is when the word is consumed.
    task automatic cyc(input bit wi, input logic [7:0] di, input bit ri);
        bit wa, ra;
        winc = wi; wdata = di; rinc = ri;
        wa = wi && (q.size() < 16);
        ra = ri && (q.size() > 0);
        last_pop = ra;
        if (ra) last_exp = q[0];
        last_rd = rdata;
        @(posedge clk); #1;
        if (ra) void'(q.pop_front());
        if (wa) q.push_back(di);
        winc = 1'b0; rinc = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1; winc = 1'b1; rinc = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; winc = 1'b0; rinc = 1'b0;
        q.delete();
    endtask

    task automatic test_reset();
        winc = 1'b1; rinc = 1'b1; wdata = 8'h77;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0; winc = 1'b0; rinc = 1'b0;
        q.delete();
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL reset_rempty: got %b expected 1", rempty); end
        checks++; if (wfull !== 1'b0) begin errors++; $display("FAIL reset_wfull: got %b expected 0", wfull); end
        checks++; if (walmost_full !== 1'b0) begin errors++; $display("FAIL reset_afull: got %b expected 0", walmost_full); end
        checks++; if (ralmost_empty !== 1'b1) begin errors++; $display("FAIL reset_aempty: got %b expected 1", ralmost_empty); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_sticky: got %b%b expected 00", overflow, underflow); end
        checks++; if (rempty2 !== 1'b1 || ralmost_empty2 !== 1'b1 || count2 !== 5'd0) begin errors++; $display("FAIL reset_dut2: got %b%b %0d expected 11 0", rempty2, ralmost_empty2, count2); end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 8'(i), 1'b0);
            checks++; if (count !== 5'(i+1)) begin errors++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, i+1); end
            checks++; if (walmost_full !== (i+1 >= 14)) begin errors++; $display("FAIL fill_afull[%0d]: got %b expected %b", i, walmost_full, (i+1 >= 14)); end
            checks++; if (wfull !== (i == 15)) begin errors++; $display("FAIL fill_wfull[%0d]: got %b expected %b", i, wfull, (i == 15)); end
            checks++; if (ralmost_empty !== (i+1 <= 2)) begin errors++; $display("FAIL fill_aempty[%0d]: got %b expected %b", i, ralmost_empty, (i+1 <= 2)); end
            checks++; if (rempty !== 1'b0) begin errors++; $display("FAIL fill_rempty[%0d]: got %b expected 0", i, rempty); end
        end
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            checks++; if (last_rd !== 8'(i)) begin errors++; $display("FAIL drain_data[%0d]: got %0h expected %0h", i, last_rd, i); end
            checks++; if (count !== 5'(15-i)) begin errors++; $display("FAIL drain_count[%0d]: got %0d expected %0d", i, count, 15-i); end
            checks++; if (ralmost_empty !== (15-i <= 2)) begin errors++; $display("FAIL drain_aempty[%0d]: got %b expected %b", i, ralmost_empty, (15-i <= 2)); end
            checks++; if (rempty !== (i == 15)) begin errors++; $display("FAIL drain_rempty[%0d]: got %b expected %b", i, rempty, (i == 15)); end
            checks++; if (wfull !== 1'b0) begin errors++; $display("FAIL drain_wfull[%0d]: got %b expected 0", i, wfull); end
        end
    endtask

    task automatic test_errors();
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0);
        cyc(1'b1, 8'hEE, 1'b0);
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count: got %0d expected 16", count); end
        checks++; if (overflow !== 1'b1 || underflow !== 1'b0) begin errors++; $display("FAIL ovf_flags: got %b%b expected 10", overflow, underflow); end
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_hold: got %b expected 1", overflow); end
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            checks++; if (last_rd !== 8'(8'h40 + i)) begin errors++; $display("FAIL ovf_data[%0d]: got %0h expected %0h", i, last_rd, 8'h40 + i); end
        end
        cyc(1'b0, 8'h00, 1'b1);
        checks++; if (count !== 5'd0 || rempty !== 1'b1) begin errors++; $display("FAIL udf_count: got %0d/%b expected 0/1", count, rempty); end
        checks++; if (underflow !== 1'b1 || overflow !== 1'b1) begin errors++; $display("FAIL udf_flags: got %b%b expected 11", overflow, underflow); end
        cyc(1'b0, 8'h00, 1'b0);
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL udf_hold: got %b expected 1", underflow); end
        pulse_clr();
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL clr_sticky: got %b%b expected 00", overflow, underflow); end
        checks++; if (count !== 5'd0 || rempty !== 1'b1 || ralmost_empty !== 1'b1) begin errors++; $display("FAIL clr_state: got %0d %b%b expected 0 11", count, rempty, ralmost_empty); end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0);
        cyc(1'b1, 8'hAA, 1'b1);
        checks++; if (count !== 5'd15) begin errors++; $display("FAIL simfull_count: got %0d expected 15", count); end
        checks++; if (wfull !== 1'b0 || overflow !== 1'b1) begin errors++; $display("FAIL simfull_flags: got wfull=%b ovf=%b expected 0 1", wfull, overflow); end
        checks++; if (last_rd !== 8'h10) begin errors++; $display("FAIL simfull_rd: got %0h expected 10", last_rd); end
        for (int i = 1; i < 16; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            checks++; if (last_rd !== 8'(8'h10 + i)) begin errors++; $display("FAIL simfull_drain[%0d]: got %0h expected %0h", i, last_rd, 8'h10 + i); end
        end
        checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL simfull_empty: got %b expected 1", rempty); end
        cyc(1'b1, 8'h3C, 1'b1);
        checks++; if (count !== 5'd1 || rempty !== 1'b0) begin errors++; $display("FAIL simempty_count: got %0d/%b expected 1/0", count, rempty); end
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL simempty_udf: got %b expected 1", underflow); end
        checks++; if (rdata !== 8'h3C) begin errors++; $display("FAIL simempty_rdata: got %0h expected 3c", rdata); end
        pulse_clr();
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0);
        for (int k = 0; k < 40; k++) begin
            cyc(1'b1, 8'(8'hC5 + k), 1'b1);
            checks++; if (last_rd !== 8'(8'hC0 + k)) begin errors++; $display("FAIL wrap_data[%0d]: got %0h expected %0h", k, last_rd, 8'hC0 + k); end
            checks++; if (count !== 5'd5) begin errors++; $display("FAIL wrap_count[%0d]: got %0d expected 5", k, count); end
            checks++; if ({wfull, rempty, walmost_full, ralmost_empty, overflow, underflow} !== 6'b0) begin errors++; $display("FAIL wrap_flags[%0d]: got %b expected 000000", k, {wfull, rempty, walmost_full, ralmost_empty, overflow, underflow}); end
        end
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            checks++; if (!last_pop || last_rd !== last_exp) begin errors++; $display("FAIL wrap_drain[%0d]: got %0h expected %0h", i, last_rd, last_exp); end
        end
        checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b expected 1", rempty); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 9; i++) cyc(1'b1, 8'(8'h90 + i), 1'b0);
        checks++; if (count !== 5'd9) begin errors++; $display("FAIL rstmid_pre: got %0d expected 9", count); end
        rst = 1'b1; winc = 1'b1; rinc = 1'b1; wdata = 8'hFF;
        @(posedge clk); #1;
        rst = 1'b0; winc = 1'b0; rinc = 1'b0;
        q.delete();
        checks++; if (count !== 5'd0 || rempty !== 1'b1 || wfull !== 1'b0) begin errors++; $display("FAIL rstmid_state: got %0d %b%b expected 0 10", count, rempty, wfull); end
        checks++; if (walmost_full !== 1'b0 || ralmost_empty !== 1'b1) begin errors++; $display("FAIL rstmid_almost: got %b%b expected 01", walmost_full, ralmost_empty); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL rstmid_sticky: got %b%b expected 00", overflow, underflow); end
        cyc(1'b1, 8'h5A, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        checks++; if (last_rd !== 8'h5A) begin errors++; $display("FAIL rstmid_data: got %0h expected 5a", last_rd); end
        checks++; if (rempty !== 1'b1 || count !== 5'd0) begin errors++; $display("FAIL rstmid_after: got %b/%0d expected 1/0", rempty, count); end
    endtask

    task automatic test_thresholds();
        logic [7:0] q2[$];
        bit wi, ri, wa, ra;
        logic [7:0] di, seen;
        int full_seen = 0, empty_seen = 0;
        for (int c = 0; c < 500; c++) begin
            // Bias writes early and reads later so both boundaries are visited.
            wi = ($urandom_range(0, 99) < ((c % 200) < 100 ? 75 : 25));
            ri = ($urandom_range(0, 99) < ((c % 200) < 100 ? 25 : 75));
            di = 8'($urandom);
            winc2 = wi; rinc2 = ri; wdata2 = di;
            wa = wi && (q2.size() < 16);
            ra = ri && (q2.size() > 0);
            seen = rdata2;
            checks++; if (ra && seen !== q2[0]) begin errors++; $display("FAIL thr_data[%0d]: got %0h expected %0h", c, seen, q2[0]); end
            @(posedge clk); #1;
            if (ra) void'(q2.pop_front());
            if (wa) q2.push_back(di);
            if (q2.size() == 16) full_seen++;
            if (q2.size() == 0) empty_seen++;
            checks++; if (wfull2 !== (q2.size() == 16) || walmost_full2 !== (q2.size() == 16)) begin errors++; $display("FAIL thr_full[%0d]: got wfull=%b afull=%b expected %b", c, wfull2, walmost_full2, (q2.size() == 16)); end
            checks++; if (rempty2 !== (q2.size() == 0) || ralmost_empty2 !== (q2.size() == 0)) begin errors++; $display("FAIL thr_empty[%0d]: got rempty=%b aempty=%b expected %b", c, rempty2, ralmost_empty2, (q2.size() == 0)); end
            checks++; if (count2 !== 5'(q2.size())) begin errors++; $display("FAIL thr_count[%0d]: got %0d expected %0d", c, count2, q2.size()); end
        end
        winc2 = 1'b0; rinc2 = 1'b0;
        checks++; if (full_seen == 0 || empty_seen == 0) begin errors++; $display("FAIL thr_coverage: got full=%0d empty=%0d expected both nonzero", full_seen, empty_seen); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_errors();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
        test_thresholds();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO with integrated storage, registered full/empty and programmable almost-full/almost-empty flags, an occupancy count, sticky overflow/underflow error flags and a synchronous flush. It serves same-clock-domain buffering and rate smoothing, where a dual-clock Gray-pointer FIFO is unnecessary. Pointers are binary with an extra wrap bit. All status flags are registered and computed from next-state values, so they are valid at the edge that changes occupancy.

## Interface
- DATASIZE, 8, data word width in bits.
- ADDRSIZE, 4, log2 of depth; DEPTH = 2**ADDRSIZE.
- AFULL_LVL, DEPTH-2, walmost_full asserts when occupancy >= AFULL_LVL; legal range 1..DEPTH.
- AEMPTY_LVL, 2, ralmost_empty asserts when occupancy <= AEMPTY_LVL; legal range 0..DEPTH-1.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  synchronous reset, active-high.
- clr  in  1  synchronous flush, active-high.
- winc  in  1  write request.
- wdata  in  DATASIZE  write data.
- rinc  in  1  read request.
- rdata  out  DATASIZE  head-of-queue word; combinational from storage; valid while !rempty.
- wfull  out  1  FIFO full.
- rempty  out  1  FIFO empty.
- walmost_full  out  1  occupancy >= AFULL_LVL.
- ralmost_empty  out  1  occupancy <= AEMPTY_LVL.
- count  out  ADDRSIZE+1  occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

## Operation
- Internal state: wptr and rptr, ADDRSIZE+1 bits binary. The address is the low ADDRSIZE bits. The MSB is the wrap bit.
- Write accepted (wa) = winc & ~wfull. On wa: mem[wptr[ADDRSIZE-1:0]] <= wdata and wptr += 1.
- Read accepted (ra) = rinc & ~rempty. On ra: rptr += 1.
- Acceptance is decided only from current registered flags.
  - Write+read while full: the read is accepted, the write is rejected, overflow is set, and count decrements.
  - Write+read while empty: the write is accepted, the read is rejected, underflow is set, and count increments.
  - Write+read otherwise: both are accepted and count is unchanged.
- Next-state count: count_next = count + wa - ra.
- Registered flags:
  - wfull <= (wptr_next[ADDRSIZE] != rptr_next[ADDRSIZE]) && (addresses equal).
  - rempty <= (wptr_next == rptr_next).
  - walmost_full <= count_next >= AFULL_LVL.
  - ralmost_empty <= count_next <= AEMPTY_LVL.
  - count <= count_next.
- Sticky error flags:
  - overflow <= overflow | (winc & wfull).
  - underflow <= underflow | (rinc & rempty).
  - Both clear only on rst or clr.
- Pointer wrap is natural modulo-2**(ADDRSIZE+1) rollover; there is no special case at DEPTH.
- Priority is rst > clr > normal operation.
  - rst or clr: pointers = 0, count = 0, rempty = 1, wfull = 0, walmost_full = 0, ralmost_empty = 1, overflow = underflow = 0.
  - winc/rinc are ignored in a clr cycle.
  - Memory contents are not reset.
- rdata = mem[rptr[ADDRSIZE-1:0]]. Its value while rempty=1 is don't-care.

## Timing
- Reset values (after the first rising edge with rst=1): count=0, rempty=1, wfull=0, walmost_full=0, ralmost_empty=1, overflow=0, underflow=0.
- Write latency: a word written at edge n is visible on rdata, and rempty is 0, after edge n; it is readable in cycle n+1.
- Read: the consuming edge advances rptr. The next word appears on rdata after that edge.
- All flags and count update at the same edge as the accepting event, with no extra cycle of lag.
- rst or clr mid-operation takes effect at that edge. In-flight requests in that cycle are discarded and do not set sticky flags.
- Throughput: one write and one read per cycle sustained.

## Test plan
- Fill/drain (DATASIZE=8, ADDRSIZE=4):
  - Stimulus: 16 writes of 0x00..0x0F.
  - Required: wfull=1 after the 16th edge, count=16, walmost_full=1 from count 14.
  - Then 16 reads return 0x00..0x0F in order, rempty=1 after the last read, ralmost_empty=1 from count 2.
- Overflow/underflow:
  - Stimulus: write while full; read while empty.
  - Required: count unchanged, data unchanged, the matching sticky flag sets and holds until clr.
  - Then clr: both flags clear the next cycle.
- Simultaneous at boundaries:
  - Stimulus: winc & rinc while full (wdata=0xAA).
  - Required: count 16 -> 15, wfull=0, overflow=1, 0xAA not stored.
  - Stimulus: winc & rinc while empty.
  - Required: count 0 -> 1, rdata=wdata, underflow=1.
- Wrap-around: 40 cycles of continuous simultaneous write/read at occupancy 5, so both pointers wrap twice. Required: count=5 throughout, data in order, no flag change.
- Reset mid-operation:
  - Stimulus: assert rst at count=9 with winc=rinc=1 in that cycle.
  - Required: all outputs at reset values the next cycle, no sticky flags set.
  - Then a subsequent write of 0x5A is read back as 0x5A.
- Threshold parameters:
  - Stimulus: AFULL_LVL=DEPTH, AEMPTY_LVL=0.
  - Required: walmost_full tracks wfull exactly and ralmost_empty tracks rempty exactly over a random 500-cycle traffic run, checked against a reference queue model.
